// File: rtl/fuzzy_demapping_if.sv
// Purpose : handshake/data bundle between the fuzzy inference layer and the demapper.
// Ports   : InValid/InReady + LoaclFlag/LongBitData (request side),
//           OutValid/OutReady + OutFixed/IsHit/ErrorReturn (result side).
// master = producer of requests / consumer of results; slave = the demapper.
interface fuzzy_demapping_if #(
  parameter int OutData_limit = 4,
  parameter int LongBit_limit = 10
);
  logic                     InValid;
  logic                     InReady;
  logic [2:0]               LoaclFlag;
  logic [LongBit_limit-1:0] LongBitData;
  logic                     OutValid;
  logic                     OutReady;
  logic [OutData_limit-1:0] OutFixed;
  logic                     IsHit;
  logic                     ErrorReturn;

  modport master (
    output InValid, LoaclFlag, LongBitData, OutReady,
    input  InReady, OutValid, OutFixed, IsHit, ErrorReturn
  );

  modport slave (
    input  InValid, LoaclFlag, LongBitData, OutReady,
    output InReady, OutValid, OutFixed, IsHit, ErrorReturn
  );
endinterface

// File: rtl/fuzzy_demapping.sv
// Purpose : rebuild a crisp value from a region flag + thermometer code (serial count, subtract-loop divide).
// Latency : L + q + 2 cycles from accept to OutValid (q = quotient, 0 for core / out-of-range / error).
// Backpres: single transaction in flight; InReady only in IDLE, result held in DONE until OutReady.
// Ports   : Clk, Rst_n (async active-low), bus (fuzzy_demapping_if.slave).
// Option  : define FUZZY_DEMAP_ROUND_EN for round-half-up instead of truncating division.
module fuzzy_demapping #(
  parameter int OutData_limit = 4,
  parameter int LongBit_limit = 10,
  parameter int Node0 = 0,
  parameter int Node1 = 1,
  parameter int Node2 = 2,
  parameter int Node3 = 3
) (
  input  logic                Clk,
  input  logic                Rst_n,
  fuzzy_demapping_if.slave    bus
);

  localparam int          W         = OutData_limit;
  localparam int          L         = LongBit_limit;
  localparam logic [31:0] L_U       = 32'(L);
  localparam logic [31:0] UP_SPAN   = 32'(Node1 - Node0);
  localparam logic [31:0] DOWN_SPAN = 32'(Node3 - Node2);
`ifdef FUZZY_DEMAP_ROUND_EN
  localparam logic [31:0] REM_BIAS  = 32'(L / 2);
`else
  localparam logic [31:0] REM_BIAS  = 32'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DIV, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [L-1:0]   r_shift;
  logic [2:0]     r_flag;
  logic [31:0]    r_cnt;
  logic [31:0]    r_bit_idx;
  logic           r_seen_zero;
  logic           r_err;
  logic [31:0]    r_rem;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_out_fixed;
  logic           r_is_hit;
  logic           r_err_ret;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_bit;
  logic [31:0]    w_cnt_nxt;
  logic           w_err_nxt;
  logic           w_last_bit;
  logic           w_div_go;
  logic [31:0]    w_rem_load;
  logic [W-1:0]   w_result;
  logic           w_hit;

  assign w_bit      = r_shift[0];
  assign w_cnt_nxt  = r_cnt + {31'd0, w_bit};
  // A one arriving after any zero means the code is not a packed thermometer.
  assign w_err_nxt  = r_err | (r_seen_zero & w_bit);
  assign w_last_bit = (r_bit_idx == L_U - 32'd1);
  assign w_div_go   = (r_rem >= L_U);

  // Dividend for the selected region; down slope outranks core, core outranks up.
  // Core, out-of-range and errors load 0 so DIV exits after one cycle.
  always_comb begin
    w_rem_load = 32'd0;
    if (!w_err_nxt) begin
      if (r_flag[0])      w_rem_load = w_cnt_nxt * DOWN_SPAN + REM_BIAS;
      else if (r_flag[1]) w_rem_load = 32'd0;
      else if (r_flag[2]) w_rem_load = w_cnt_nxt * UP_SPAN + REM_BIAS;
    end
  end

  always_comb begin
    w_result = '0;
    w_hit    = 1'b0;
    if (!r_err) begin
      if (r_flag[0])      w_result = W'(Node3) - r_q;
      else if (r_flag[1]) w_result = W'(Node1);
      else if (r_flag[2]) w_result = W'(Node0) + r_q;
      else                w_hit    = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.InValid) w_state_nxt = S_COUNT;
      end
      S_COUNT: if (w_last_bit) w_state_nxt = S_DIV;
      S_DIV:   if (!w_div_go)  w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.OutReady) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_shift     <= '0;
      r_flag      <= '0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_seen_zero <= 1'b0;
      r_err       <= 1'b0;
      r_rem       <= '0;
      r_q         <= '0;
      r_out_fixed <= '0;
      r_is_hit    <= 1'b0;
      r_err_ret   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.InValid) begin
          r_shift     <= bus.LongBitData;
          r_flag      <= bus.LoaclFlag;
          r_cnt       <= '0;
          r_bit_idx   <= '0;
          r_seen_zero <= 1'b0;
          r_err       <= 1'b0;
          r_rem       <= '0;
          r_q         <= '0;
        end
        S_COUNT: begin
          r_shift     <= r_shift >> 1;
          r_cnt       <= w_cnt_nxt;
          r_err       <= w_err_nxt;
          r_seen_zero <= r_seen_zero | ~w_bit;
          r_bit_idx   <= r_bit_idx + 32'd1;
          if (w_last_bit) begin
            r_rem <= w_rem_load;
            r_q   <= '0;
          end
        end
        S_DIV: begin
          if (w_div_go) begin
            r_rem <= r_rem - L_U;
            r_q   <= r_q + W'(1);
          end else begin
            r_out_fixed <= w_result;
            r_is_hit    <= w_hit;
            r_err_ret   <= r_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.InReady     = w_in_ready;
  assign bus.OutValid    = w_out_valid;
  assign bus.OutFixed    = r_out_fixed;
  assign bus.IsHit       = r_is_hit;
  assign bus.ErrorReturn = r_err_ret;

endmodule

// File: tb/tb_fuzzy_demapping.sv
// Purpose : scoreboard bench for fuzzy_demapping (defaults L=10, nodes 0/1/2/3).
// Latency : expected accept-to-OutValid latency is part of each scoreboard entry.
// Backpres: exercises held OutReady, ignored InValid while busy, and mid-transaction reset.
module tb_fuzzy_demapping;

  localparam int W  = 4;
  localparam int L  = 10;
  localparam int N0 = 0;
  localparam int N1 = 1;
  localparam int N2 = 2;
  localparam int N3 = 3;
`ifdef FUZZY_DEMAP_ROUND_EN
  localparam int BIAS = L / 2;
`else
  localparam int BIAS = 0;
`endif

  typedef struct {
    logic [W-1:0] fixed;
    logic         hit;
    logic         err;
    int           lat;
  } exp_t;

  logic Clk;
  logic Rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  fuzzy_demapping_if #(.OutData_limit(W), .LongBit_limit(L)) bus_if ();

  fuzzy_demapping #(
    .OutData_limit(W), .LongBit_limit(L),
    .Node0(N0), .Node1(N1), .Node2(N2), .Node3(N3)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_if.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: count ones, flag holes, then an ordinary integer divide.
  function automatic exp_t model(input logic [2:0] f, input logic [L-1:0] c);
    exp_t m;
    int   cnt = 0;
    bit   seen0 = 0;
    bit   e = 0;
    int   q = 0;
    for (int i = 0; i < L; i++) begin
      if (c[i]) begin
        cnt++;
        if (seen0) e = 1;
      end else seen0 = 1;
    end
    m.fixed = '0; m.hit = 1'b0; m.err = e;
    if (!e) begin
      if (f[0]) begin
        q = (cnt * (N3 - N2) + BIAS) / L;
        m.fixed = W'(N3 - q);
      end else if (f[1]) begin
        m.fixed = W'(N1);
      end else if (f[2]) begin
        q = (cnt * (N1 - N0) + BIAS) / L;
        m.fixed = W'(N0 + q);
      end else m.hit = 1'b1;
    end
    m.lat = L + q + 2;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Called only while the DUT is in IDLE; the following edge is the accept edge.
  task automatic send(input logic [2:0] f, input logic [L-1:0] c);
    bus_if.LoaclFlag   = f;
    bus_if.LongBitData = c;
    bus_if.InValid     = 1'b1;
    sb.push_back(model(f, c));
    tick(1);
    bus_if.InValid = 1'b0;
  endtask

  // Waits (bounded) for OutValid; lat = -1 on timeout.
  task automatic get_result(output logic [W-1:0] fx, output logic h, output logic e,
                            output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (bus_if.OutValid === 1'b1) begin
        lat = i + 1;  // accept edge already consumed inside send
        break;
      end
    end
    fx = bus_if.OutFixed;
    h  = bus_if.IsHit;
    e  = bus_if.ErrorReturn;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    bus_if.InValid = 1'b0; bus_if.OutReady = 1'b1;
    bus_if.LoaclFlag = '0; bus_if.LongBitData = '0;
    #2;
    tick(2);
    checks++; if (bus_if.InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", bus_if.InReady); end
    checks++; if (bus_if.OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", bus_if.OutValid); end
    checks++; if (bus_if.OutFixed !== 4'd0) begin failures++; $display("FAIL reset_outfixed got=%0d exp=0", bus_if.OutFixed); end
    checks++; if (bus_if.IsHit !== 1'b0) begin failures++; $display("FAIL reset_ishit got=%b exp=0", bus_if.IsHit); end
    checks++; if (bus_if.ErrorReturn !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_if.ErrorReturn); end
    Rst_n = 1'b1;
    tick(1);
  endtask

  // Runs a list of transactions back to back with OutReady held high.
  task automatic run_list(input string name, input logic [2:0] fl[], input logic [L-1:0] cd[]);
    logic [W-1:0] fx; logic h, e; int lat; exp_t x;
    for (int i = 0; i < fl.size(); i++) begin
      send(fl[i], cd[i]);
      get_result(fx, h, e, lat);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin failures++; $display("FAIL %s[%0d]_latency got=%0d exp=%0d", name, i, lat, x.lat); end
      checks++; if (fx !== x.fixed) begin failures++; $display("FAIL %s[%0d]_outfixed got=%0d exp=%0d", name, i, fx, x.fixed); end
      checks++; if (h !== x.hit) begin failures++; $display("FAIL %s[%0d]_ishit got=%b exp=%b", name, i, h, x.hit); end
      checks++; if (e !== x.err) begin failures++; $display("FAIL %s[%0d]_err got=%b exp=%b", name, i, e, x.err); end
      tick(1);  // DONE -> IDLE
    end
  endtask

  task automatic test_slopes;
    run_list("slopes", '{3'b100, 3'b001, 3'b100, 3'b001, 3'b001},
                       '{10'h01F, 10'h07F, 10'h3FF, 10'h000, 10'h3FF});
  endtask

  task automatic test_priority;
    run_list("priority", '{3'b011, 3'b110, 3'b111, 3'b010}, '{10'h3FF, 10'h3FF, 10'h00F, 10'h000});
  endtask

  task automatic test_error_hit;
    run_list("error_hit", '{3'b100, 3'b000, 3'b001, 3'b010, 3'b000},
                          '{10'h017, 10'h0FF, 10'h200, 10'h001, 10'h3FE});
  endtask

  task automatic test_backpressure;
    logic [W-1:0] fx; logic h, e; int lat; exp_t x;
    bus_if.OutReady = 1'b0;
    send(3'b001, 10'h07F);
    get_result(fx, h, e, lat);
    x = sb.pop_front();
    checks++; if (fx !== x.fixed) begin failures++; $display("FAIL bp_outfixed got=%0d exp=%0d", fx, x.fixed); end
    for (int i = 0; i < 5; i++) begin
      bus_if.InValid   = (i == 2);
      bus_if.LoaclFlag = 3'b010;
      tick(1);
      checks++; if (bus_if.OutValid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, bus_if.OutValid); end
      checks++; if (bus_if.OutFixed !== x.fixed || bus_if.IsHit !== x.hit || bus_if.ErrorReturn !== x.err) begin
        failures++; $display("FAIL bp_hold_data[%0d] got=%0d/%b/%b exp=%0d/%b/%b", i, bus_if.OutFixed,
                             bus_if.IsHit, bus_if.ErrorReturn, x.fixed, x.hit, x.err); end
      checks++; if (bus_if.InReady !== 1'b0) begin failures++; $display("FAIL bp_inready[%0d] got=%b exp=0", i, bus_if.InReady); end
    end
    bus_if.InValid  = 1'b0;
    bus_if.OutReady = 1'b1;
    tick(1);
    checks++; if (bus_if.OutValid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus_if.OutValid); end
    checks++; if (bus_if.InReady !== 1'b1) begin failures++; $display("FAIL bp_release_inready got=%b exp=1", bus_if.InReady); end
    tick(3);
    checks++; if (bus_if.InReady !== 1'b1) begin failures++; $display("FAIL bp_ignored_pulse got=%b exp=1", bus_if.InReady); end
  endtask

  task automatic test_reset_midop;
    int seen = 0;
    send(3'b001, 10'h3FF);
    tick(3);  // now inside the 4th COUNT cycle
    Rst_n = 1'b0;
    void'(sb.pop_back());  // aborted transaction produces nothing
    #1;
    checks++; if (bus_if.InReady !== 1'b1) begin failures++; $display("FAIL midrst_inready got=%b exp=1", bus_if.InReady); end
    checks++; if (bus_if.OutValid !== 1'b0) begin failures++; $display("FAIL midrst_outvalid got=%b exp=0", bus_if.OutValid); end
    checks++; if (bus_if.OutFixed !== 4'd0 || bus_if.IsHit !== 1'b0 || bus_if.ErrorReturn !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%0d/%b/%b exp=0/0/0", bus_if.OutFixed, bus_if.IsHit, bus_if.ErrorReturn); end
    tick(1);
    Rst_n = 1'b1;
    for (int i = 0; i < L + 6; i++) begin
      tick(1);
      if (bus_if.OutValid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_output got=%0d exp=0", seen); end
    run_list("after_reset", '{3'b100}, '{10'h3FF});
  endtask

  task automatic test_back_to_back;
    logic [2:0]   fl[] = new[8];
    logic [L-1:0] cd[] = new[8];
    logic [L-1:0] ones;
    for (int i = 0; i < 8; i++) begin
      ones  = '1;
      fl[i] = 3'($urandom_range(0, 7));
      cd[i] = ones >> $urandom_range(0, L);
    end
    run_list("b2b", fl, cd);
  endtask

  initial begin
    test_reset();
    test_slopes();
    test_priority();
    test_error_hit();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_empty got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
